// File: rtl/sccb_slave_responder_if.sv
// rtl/sccb_slave_responder_if.sv - SCCB pad, write-report and host-read signals of the responder
interface sccb_slave_responder_if #(
  parameter int ADDR_BITS = 8
);
  logic                 scl_i;
  logic                 sda_i;
  logic                 sda_oe;
  logic                 wr_valid;
  logic [15:0]          wr_addr;
  logic [7:0]           wr_data;
  logic                 busy;
  logic [ADDR_BITS-1:0] host_raddr;
  logic [7:0]           host_rdata;

  modport slave (
    input  scl_i, sda_i, host_raddr,
    output sda_oe, wr_valid, wr_addr, wr_data, busy, host_rdata
  );

  modport master (
    output scl_i, sda_i, host_raddr,
    input  sda_oe, wr_valid, wr_addr, wr_data, busy, host_rdata
  );
endinterface

// File: rtl/sccb_slave_responder.sv
// rtl/sccb_slave_responder.sv - SCCB target with register file; SCCB_SLAVE_AUTOINC_EN enables pointer auto-increment
module sccb_slave_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'h3C,
  parameter int         ADDR_BITS = 8,
  parameter int         FILTER    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sccb_slave_responder_if.slave  bus
);
  localparam int CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_DEV       = 4'd1;
  localparam logic [3:0] S_DEV_ACK   = 4'd2;
  localparam logic [3:0] S_SUBH      = 4'd3;
  localparam logic [3:0] S_SUBH_ACK  = 4'd4;
  localparam logic [3:0] S_SUBL      = 4'd5;
  localparam logic [3:0] S_SUBL_ACK  = 4'd6;
  localparam logic [3:0] S_WDATA     = 4'd7;
  localparam logic [3:0] S_WDATA_ACK = 4'd8;
  localparam logic [3:0] S_RDATA     = 4'd9;
  localparam logic [3:0] S_RMACK     = 4'd10;
  localparam logic [3:0] S_IGNORE    = 4'd11;

  logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_f_q, scl_f_d, scl_prev_q;
  logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_f_q, sda_f_d, sda_prev_q;
  logic [CW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

  logic [3:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        phase_q, phase_d;
  logic [15:0] ptr_q, ptr_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        wr_valid_q, wr_valid_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  host_rdata_q, host_rdata_d;
  logic [7:0]  mem_q [2**ADDR_BITS];

  logic scl_rise, scl_fall, start_cond, stop_cond, last_bit, mem_we;
  logic [7:0] rx_byte, rd_byte;

  // Synchronise both lines, then only move the filtered level after FILTER agreeing samples
  always_comb begin
    scl_s1_d  = bus.scl_i;
    scl_s2_d  = scl_s1_q;
    sda_s1_d  = bus.sda_i;
    sda_s2_d  = sda_s1_q;
    scl_f_d   = scl_f_q;
    sda_f_d   = sda_f_q;
    scl_cnt_d = '0;
    sda_cnt_d = '0;
    if (scl_s2_q != scl_f_q) begin
      if (scl_cnt_q == CNT_MAX) scl_f_d = scl_s2_q;
      else                      scl_cnt_d = scl_cnt_q + 1'b1;
    end
    if (sda_s2_q != sda_f_q) begin
      if (sda_cnt_q == CNT_MAX) sda_f_d = sda_s2_q;
      else                      sda_cnt_d = sda_cnt_q + 1'b1;
    end
  end

  assign scl_rise   = scl_f_q & ~scl_prev_q;
  assign scl_fall   = ~scl_f_q & scl_prev_q;
  assign start_cond = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
  assign stop_cond  = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;
  assign rx_byte    = {shift_q[6:0], sda_f_q};
  assign last_bit   = (bit_cnt_q == 3'd7);
  assign rd_byte    = mem_q[ptr_q[ADDR_BITS-1:0]];

  // Protocol FSM: bits sampled on filtered SCL rise, SDA drive changed only on filtered SCL fall
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    phase_d    = phase_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;
    if (stop_cond) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_cond) begin
      state_d   = S_DEV;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      bit_cnt_d = 3'd0;
      phase_d   = 1'b0;
    end else begin
      case (state_q)
        S_DEV, S_SUBH, S_SUBL, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              phase_d = 1'b0;
              case (state_q)
                S_DEV:   state_d = (rx_byte[7:1] == DEV_ADDR) ? S_DEV_ACK : S_IGNORE;
                S_SUBH: begin
                  ptr_d[15:8] = rx_byte;
                  state_d     = S_SUBH_ACK;
                end
                S_SUBL: begin
                  ptr_d[7:0] = rx_byte;
                  state_d    = S_SUBL_ACK;
                end
                default: begin
                  mem_we     = 1'b1;
                  wr_valid_d = 1'b1;
                  wr_addr_d  = ptr_q;
                  wr_data_d  = rx_byte;
`ifdef SCCB_SLAVE_AUTOINC_EN
                  ptr_d      = ptr_q + 16'd1;
`endif
                  state_d    = S_WDATA_ACK;
                end
              endcase
            end
          end
        end
        S_DEV_ACK, S_SUBH_ACK, S_SUBL_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              phase_d   = 1'b0;
              bit_cnt_d = 3'd0;
              case (state_q)
                S_DEV_ACK: begin
                  if (shift_q[0]) begin
                    state_d  = S_RDATA;
                    sda_oe_d = ~rd_byte[7];
                    shift_d  = {rd_byte[6:0], 1'b0};
                    phase_d  = 1'b1;
                  end else begin
                    state_d = S_SUBH;
                  end
                end
                S_SUBH_ACK: state_d = S_SUBL;
                default:    state_d = S_WDATA;
              endcase
            end
          end
        end
        S_RDATA: begin
          if (!phase_q) begin
            if (scl_fall) begin
              sda_oe_d  = ~rd_byte[7];
              shift_d   = {rd_byte[6:0], 1'b0};
              phase_d   = 1'b1;
              bit_cnt_d = 3'd0;
            end
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              state_d = S_RMACK;
              phase_d = 1'b0;
            end
          end else if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
          end
        end
        S_RMACK: begin
          if (!phase_q) begin
            if (scl_fall) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b1;
            end
          end else if (scl_rise) begin
            phase_d = 1'b0;
            if (!sda_f_q) begin
`ifdef SCCB_SLAVE_AUTOINC_EN
              ptr_d   = ptr_q + 16'd1;
`endif
              state_d = S_RDATA;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_IDLE, S_IGNORE: state_d = state_q;
        default:          state_d = S_IDLE;
      endcase
    end
  end

  assign host_rdata_d = mem_q[bus.host_raddr];

  // State, conditioning and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q     <= 1'b1;
      scl_s2_q     <= 1'b1;
      scl_f_q      <= 1'b1;
      scl_prev_q   <= 1'b1;
      scl_cnt_q    <= '0;
      sda_s1_q     <= 1'b1;
      sda_s2_q     <= 1'b1;
      sda_f_q      <= 1'b1;
      sda_prev_q   <= 1'b1;
      sda_cnt_q    <= '0;
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      phase_q      <= 1'b0;
      ptr_q        <= 16'h0000;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= 16'h0000;
      wr_data_q    <= 8'h00;
      host_rdata_q <= 8'h00;
    end else begin
      scl_s1_q     <= scl_s1_d;
      scl_s2_q     <= scl_s2_d;
      scl_f_q      <= scl_f_d;
      scl_prev_q   <= scl_f_q;
      scl_cnt_q    <= scl_cnt_d;
      sda_s1_q     <= sda_s1_d;
      sda_s2_q     <= sda_s2_d;
      sda_f_q      <= sda_f_d;
      sda_prev_q   <= sda_f_q;
      sda_cnt_q    <= sda_cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      phase_q      <= phase_d;
      ptr_q        <= ptr_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Register file: cleared by reset, written on the 8th data bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**ADDR_BITS; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[ptr_q[ADDR_BITS-1:0]] <= rx_byte;
    end
  end

  assign bus.sda_oe     = sda_oe_q;
  assign bus.busy       = busy_q;
  assign bus.wr_valid   = wr_valid_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.host_rdata = host_rdata_q;
endmodule
